// File: rtl/uart_tx_arb_if.sv
// Requester and UART-transmitter signal bundle for uart_tx_arb.
// master: requesters plus transmitter status; slave: the arbiter.
interface uart_tx_arb_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic               tx_idle;

  modport master (
    output req_valid, req_data, req_last, tx_idle,
    input  req_ready, grant, busy, tx_data, tx_start
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_idle,
    output req_ready, grant, busy, tx_data, tx_start
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte sources,
// with per-message locking and a lock timeout for stalled owners.
module uart_tx_arb #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned LOCK_TO = 1023
) (
  input logic          clk,
  input logic          rst_n,
  uart_tx_arb_if.slave bus
);
  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = (LOCK_TO > 1) ? $clog2(LOCK_TO + 1) : 1;

  typedef enum logic [1:0] {ARB, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic             locked;
  logic [CW-1:0]    toCnt;
  logic [7:0]       txData;
  logic             txStart;
  logic [N_REQ-1:0] grantQ;
  logic             busyQ;

  logic             selFound;
  logic [PW-1:0]    selIdx;
  logic [PW-1:0]    candIdx;
  logic [N_REQ-1:0] selOneHot;
  logic             doXfer;
  logic             ownerIdle;
  logic             toExpire;

  // ptr is both the round-robin origin and, while locked, the owner index
  always_comb begin
    selFound = 1'b0;
    selIdx   = ptr;
    candIdx  = ptr;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      candIdx = PW'((32'(ptr) + off) % N_REQ);
      if (!selFound && bus.req_valid[candIdx] && (!locked || candIdx == ptr)) begin
        selFound = 1'b1;
        selIdx   = candIdx;
      end
    end
  end

  always_comb begin
    selOneHot         = '0;
    selOneHot[selIdx] = 1'b1;
  end

  assign doXfer    = rst_n && (state == ARB) && bus.tx_idle && selFound;
  assign ownerIdle = locked && !bus.req_valid[ptr];
  assign toExpire  = (toCnt == CW'(LOCK_TO - 1));

  assign bus.req_ready = doXfer ? selOneHot : '0;
  assign bus.grant     = grantQ;
  assign bus.busy      = busyQ;
  assign bus.tx_data   = txData;
  assign bus.tx_start  = txStart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB;
      ptr     <= PW'(N_REQ - 1);
      locked  <= 1'b0;
      toCnt   <= '0;
      txData  <= '0;
      txStart <= 1'b0;
      grantQ  <= '0;
      busyQ   <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (doXfer) begin
            txData  <= bus.req_data[8*selIdx +: 8];
            locked  <= !bus.req_last[selIdx];
            ptr     <= selIdx;
            grantQ  <= selOneHot;
            toCnt   <= '0;
            txStart <= 1'b1;
            busyQ   <= 1'b1;
            state   <= ISSUE;
          end else if (ownerIdle) begin
            // release lands on the edge where the count would reach LOCK_TO
            if (toExpire) begin
              locked <= 1'b0;
              grantQ <= '0;
              toCnt  <= '0;
            end else begin
              toCnt <= toCnt + 1'b1;
            end
          end
        end
        ISSUE: begin
          txStart <= 1'b0;
          state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!bus.tx_idle) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.tx_idle) begin
            state <= ARB;
            busyQ <= 1'b0;
            if (!locked) grantQ <= '0;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  startInIssue: assert property (@(posedge clk) disable iff (!rst_n) txStart |-> state == ISSUE);
  readyOneHot:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.req_ready));
  grantOneHot:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grantQ));
endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: behavioural UART transmitter (16 clocks/bit), line
// decoder, and a queue-based arbitration model predicting owner and byte order.
module tb_uart_tx_arb;
  localparam int unsigned NR  = 4;
  localparam int unsigned LTO = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.N_REQ(NR)) bus ();

  uart_tx_arb #(.N_REQ(NR), .LOCK_TO(LTO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // UART transmitter: reads tx_data bit-by-bit across the whole frame
  logic       txLine, uIdle;
  logic [3:0] uBit, uCnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txLine <= 1'b1; uIdle <= 1'b1; uBit <= '0; uCnt <= '0;
    end else if (uIdle) begin
      if (bus.tx_start) begin
        txLine <= 1'b0; uBit <= '0; uCnt <= '0; uIdle <= 1'b0;
      end
    end else if (uCnt == 4'd15) begin
      uCnt <= '0;
      if (uBit == 4'd9) uIdle <= 1'b1;
      else begin
        txLine <= (uBit < 4'd8) ? bus.tx_data[uBit[2:0]] : 1'b1;
        uBit   <= uBit + 4'd1;
      end
    end else begin
      uCnt <= uCnt + 4'd1;
    end
  end
  assign bus.tx_idle = uIdle;

  // line decoder, samples mid-bit; entries are {stop, data}
  logic        dAct;
  int unsigned dCnt;
  logic [7:0]  dSh;
  logic [8:0]  decQ[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dAct <= 1'b0; dCnt <= 0; dSh <= '0;
    end else if (!dAct) begin
      if (!txLine) begin dAct <= 1'b1; dCnt <= 1; end
    end else begin
      dCnt <= dCnt + 1;
      if (dCnt == 8 && txLine) dAct <= 1'b0;
      if (dCnt >= 24 && dCnt <= 136 && (dCnt % 16) == 8) dSh <= {txLine, dSh[7:1]};
      if (dCnt == 152) begin
        dAct <= 1'b0;
        decQ.push_back({txLine, dSh});
      end
    end
  end

  int unsigned totalChecks = 0, badChecks = 0;
  logic [8:0]  pend[NR][$];
  logic [7:0]  expDec[$];
  logic [7:0]  lastDec[$];
  int unsigned mPtr;
  bit          mLocked, prevXfer, expBusy, seenLow;
  int unsigned prevIdx, xferCount, holdRun, lastHold;
  logic [7:0]  expTxData;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit allEmpty();
    for (int i = 0; i < NR; i++) if (pend[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // owner keeps priority while locked and present; otherwise first valid after last owner
  function automatic int unsigned predictOwner(input logic [NR-1:0] v);
    if (mLocked && v[mPtr]) return mPtr;
    for (int unsigned k = 1; k <= NR; k++) if (v[(mPtr + k) % NR]) return (mPtr + k) % NR;
    return NR;
  endfunction

  task automatic driveInputs();
    for (int i = 0; i < NR; i++) begin
      if (pend[i].size() != 0) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_data[8*i +: 8] = pend[i][0][7:0];
        bus.req_last[i]        = pend[i][0][8];
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_data[8*i +: 8] = 8'($urandom);
        bus.req_last[i]        = 1'($urandom);
      end
    end
  endtask

  task automatic resetModel();
    mPtr = NR - 1; mLocked = 0; prevXfer = 0; expBusy = 0; seenLow = 0;
    expTxData = '0; holdRun = 0; lastHold = 0;
    expDec.delete(); decQ.delete();
    for (int i = 0; i < NR; i++) pend[i].delete();
  endtask

  task automatic tick();
    logic [NR-1:0] vset, rdy, oh;
    int unsigned   gotOwner;
    logic [8:0]    item;
    bit            xfer;
    @(negedge clk);
    vset = bus.req_valid;
    rdy  = bus.req_ready;
    checkVal("txStart", 32'(bus.tx_start), 32'(prevXfer));
    checkVal("txData", 32'(bus.tx_data), 32'(expTxData));
    checkVal("busy", 32'(bus.busy), 32'(expBusy));
    if (prevXfer) begin
      oh = '0; oh[prevIdx] = 1'b1;
      checkVal("grant", 32'(bus.grant), 32'(oh));
    end
    if (bus.tx_start) checkVal("startIdle", 32'(bus.tx_idle), 1);
    if (rdy != '0) begin
      checkVal("readyOneHot", $countones(rdy), 1);
      checkVal("readyValid", 32'(rdy & ~vset), 0);
      checkVal("readyIdle", 32'(bus.tx_idle), 1);
    end
    if (!bus.busy && bus.grant != '0) holdRun++;
    else if (holdRun != 0) begin lastHold = holdRun; holdRun = 0; end
    xfer = (rdy & vset) != '0;
    if (xfer) begin expBusy = 1; seenLow = 0; end
    else if (expBusy) begin
      if (!bus.tx_idle) seenLow = 1;
      else if (seenLow) begin expBusy = 0; seenLow = 0; end
    end
    if (xfer) begin
      gotOwner = NR;
      for (int unsigned k = 0; k < NR; k++) if (rdy[k] && gotOwner == NR) gotOwner = k;
      checkVal("owner", gotOwner, predictOwner(vset));
      item = pend[gotOwner].pop_front();
      expDec.push_back(item[7:0]);
      mPtr = gotOwner; mLocked = !item[8];
      expTxData = item[7:0]; prevIdx = gotOwner; xferCount++;
    end
    prevXfer = xfer;
    @(posedge clk);
    #1;
    driveInputs();
  endtask

  task automatic waitXfers(input string tag, input int unsigned n);
    int unsigned target = xferCount + n;
    int unsigned cyc = 0;
    while (xferCount < target && cyc < 2000) begin tick(); cyc++; end
    checkVal({tag, "_xferTimeout"}, 32'(xferCount >= target), 1);
  endtask

  task automatic drain(input string tag);
    int unsigned cyc = 0;
    while (!(allEmpty() && !bus.busy && uIdle && !dAct && decQ.size() >= expDec.size()) && cyc < 20000) begin
      tick(); cyc++;
    end
    checkVal({tag, "_drainTimeout"}, 32'(cyc < 20000), 1);
    checkVal({tag, "_count"}, decQ.size(), expDec.size());
    lastDec.delete();
    for (int i = 0; i < decQ.size(); i++) begin
      checkVal({tag, "_stop"}, 32'(decQ[i][8]), 1);
      if (i < expDec.size()) checkVal({tag, "_byte"}, 32'(decQ[i][7:0]), 32'(expDec[i]));
      lastDec.push_back(decQ[i][7:0]);
    end
    decQ.delete(); expDec.delete();
  endtask

  task automatic checkList(input string tag, input logic [7:0] want[$]);
    checkVal({tag, "_len"}, lastDec.size(), want.size());
    for (int i = 0; i < want.size() && i < lastDec.size(); i++)
      checkVal({tag, "_order"}, 32'(lastDec[i]), 32'(want[i]));
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    driveInputs();
    rst_n = 1'b1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "_txData"}, 32'(bus.tx_data), 0);
    checkVal({tag, "_txStart"}, 32'(bus.tx_start), 0);
    checkVal({tag, "_ready"}, 32'(bus.req_ready), 0);
    checkVal({tag, "_grant"}, 32'(bus.grant), 0);
    checkVal({tag, "_busy"}, 32'(bus.busy), 0);
    checkVal({tag, "_line"}, 32'(txLine), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  want[$];
    int unsigned nMsg, len;
    xferCount = 0; prevIdx = 0;
    resetModel();
    bus.req_valid = '1;
    bus.req_data  = 32'hDEADBEEF;
    bus.req_last  = '1;
    #1 rst_n = 1'b0;
    #2 checkResetOutputs("reset");
    applyReset();

    pend[0].push_back({1'b1, 8'hA5});
    driveInputs();
    drain("single");
    want = '{8'hA5};
    checkList("single", want);

    applyReset();
    for (int i = 0; i < NR; i++) pend[i].push_back({1'b1, 8'(8'h10 + i)});
    for (int i = 0; i < NR; i++) pend[i].push_back({1'b1, 8'(8'h20 + i)});
    driveInputs();
    drain("contend");
    want = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};
    checkList("contend", want);

    applyReset();
    pend[2].push_back({1'b0, 8'h55});
    pend[2].push_back({1'b0, 8'h66});
    pend[2].push_back({1'b1, 8'h77});
    driveInputs();
    waitXfers("lock", 1);
    pend[1].push_back({1'b1, 8'h88});
    driveInputs();
    drain("lock");
    want = '{8'h55, 8'h66, 8'h77, 8'h88};
    checkList("lock", want);

    applyReset();
    pend[3].push_back({1'b0, 8'h01});
    driveInputs();
    waitXfers("timeout", 1);
    pend[0].push_back({1'b1, 8'h42});
    driveInputs();
    drain("timeout");
    want = '{8'h01, 8'h42};
    checkList("timeout", want);
    checkVal("timeout_hold", lastHold, LTO);

    applyReset();
    pend[1].push_back({1'b1, 8'h99});
    driveInputs();
    waitXfers("midReset", 1);
    repeat (60) tick();
    rst_n = 1'b0;
    #1 checkResetOutputs("midReset");
    resetModel();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pend[2].push_back({1'b1, 8'h3C});
    driveInputs();
    drain("afterReset");
    want = '{8'h3C};
    checkList("afterReset", want);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NR; i++) begin
        nMsg = $urandom_range(0, 2);
        for (int m = 0; m < nMsg; m++) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) pend[i].push_back({1'(b == len - 1), 8'($urandom)});
        end
      end
      driveInputs();
      drain("random");
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end
endmodule
